seg_display_scan: RTL and testbench



---
 rtl/seg_display_scan.sv | 165 ++++++++++++++++
 tb/tb_seg_display_scan.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg_display_scan
// Brief    : Buffers one frame of per-digit segment patterns and scans it onto
//            a multiplexed seven-segment display with per-slot dead time.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_scan #(
    parameter int N_DIGITS    = 2,
    parameter int SEG_W       = 7,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD        = 16,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [N_DIGITS-1:0][SEG_W-1:0] s_data,
    output logic [N_DIGITS-1:0]            an,
    output logic [SEG_W-1:0]               seg,
    output logic                           frame_start
);

    localparam int c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_DEAD_LAST = c_CNT_W'(DEAD - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_DIG_W-1:0] c_DIG_LAST  = c_DIG_W'(N_DIGITS - 1);
    localparam logic [c_DIG_W-1:0] c_DIG_ONE   = c_DIG_W'(1);
    localparam logic               c_OFF       = ACTIVE_LOW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [c_CNT_W-1:0]            r_cnt;
    logic [c_CNT_W-1:0]            w_cnt_nxt;
    logic [c_DIG_W-1:0]            r_dig;
    logic [c_DIG_W-1:0]            w_dig_nxt;

    logic [N_DIGITS-1:0][SEG_W-1:0] r_shadow;
    logic                           r_shadow_full;
    logic [N_DIGITS-1:0][SEG_W-1:0] r_disp;
    logic [N_DIGITS-1:0][SEG_W-1:0] w_disp_nxt;

    logic                          w_xfer;
    logic                          w_accept;
    logic                          w_fs_nxt;
    logic [N_DIGITS-1:0]           w_an_log;
    logic [SEG_W-1:0]              w_seg_log;
    logic [N_DIGITS-1:0]           r_an;
    logic [SEG_W-1:0]              r_seg;
    logic                          r_frame_start;

    assign s_ready     = !r_shadow_full;
    assign w_accept    = s_valid && s_ready;
    assign an          = r_an;
    assign seg         = r_seg;
    assign frame_start = r_frame_start;

    // Scan sequencer: the slot counter runs across both BLANK and DRIVE, so a
    // digit slot is always REFRESH_DIV cycles with the first DEAD of them dark.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dig_nxt   = r_dig;
        w_xfer      = 1'b0;
        w_fs_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_shadow_full) begin
                    w_xfer      = 1'b1;
                    w_fs_nxt    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_dig_nxt   = '0;
                    w_state_nxt = (DEAD == 0) ? ST_DRIVE : ST_BLANK;
                end
            end
            ST_BLANK: begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
                if (r_cnt == c_DEAD_LAST) begin
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (DEAD == 0) ? ST_DRIVE : ST_BLANK;
                    if (r_dig == c_DIG_LAST) begin
                        // Frame boundary: the only point a pending frame may swap in.
                        w_dig_nxt = '0;
                        w_fs_nxt  = 1'b1;
                        w_xfer    = r_shadow_full;
                    end else begin
                        w_dig_nxt = r_dig + c_DIG_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output patterns are computed from the next state so an/seg line up with
    // the state register rather than lagging it by a cycle.
    always_comb begin
        w_disp_nxt = w_xfer ? r_shadow : r_disp;
        w_an_log   = '0;
        w_seg_log  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if ((w_state_nxt == ST_DRIVE) && (w_dig_nxt == c_DIG_W'(i))) begin
                w_an_log[i] = 1'b1;
                w_seg_log   = w_disp_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dig   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dig   <= w_dig_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            r_disp        <= '0;
            r_an          <= {N_DIGITS{c_OFF}};
            r_seg         <= {SEG_W{c_OFF}};
            r_frame_start <= 1'b0;
        end else begin
            // Accept and transfer are mutually exclusive: accept needs an empty shadow.
            if (w_accept) begin
                r_shadow      <= s_data;
                r_shadow_full <= 1'b1;
            end else if (w_xfer) begin
                r_shadow_full <= 1'b0;
            end
            r_disp        <= w_disp_nxt;
            r_an          <= ACTIVE_LOW ? ~w_an_log : w_an_log;
            r_seg         <= ACTIVE_LOW ? ~w_seg_log : w_seg_log;
            r_frame_start <= w_fs_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_scan
// Brief    : Two seg_display_scan instances (2-digit active-low with dead time,
//            4-digit active-high without) checked against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_scan;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    logic             sv_a = 1'b0;
    logic [1:0][6:0]  sd_a = '0;
    logic             rdy_a;
    logic [1:0]       an_a;
    logic [6:0]       seg_a;
    logic             fs_a;

    logic             sv_b = 1'b0;
    logic [3:0][6:0]  sd_b = '0;
    logic             rdy_b;
    logic [3:0]       an_b;
    logic [6:0]       seg_b;
    logic             fs_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seg_display_scan #(
        .N_DIGITS(2), .SEG_W(7), .REFRESH_DIV(8), .DEAD(2), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rstn(rstn), .s_valid(sv_a), .s_ready(rdy_a), .s_data(sd_a),
        .an(an_a), .seg(seg_a), .frame_start(fs_a)
    );

    seg_display_scan #(
        .N_DIGITS(4), .SEG_W(7), .REFRESH_DIV(5), .DEAD(0), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .rstn(rstn), .s_valid(sv_b), .s_ready(rdy_b), .s_data(sd_b),
        .an(an_b), .seg(seg_b), .frame_start(fs_b)
    );

    // Model: a display timeline t counting cycles since the first frame was
    // shown; slot, position and blanking all follow from t by division.
    bit       mst   [2];
    int       mt    [2];
    bit [6:0] mdisp [2][4];
    bit       mpend [2];
    bit [6:0] mpf   [2][4];
    bit       mfs   [2];

    function automatic int ndig(input int m);  return (m == 0) ? 2 : 4; endfunction
    function automatic int rdiv(input int m);  return (m == 0) ? 8 : 5; endfunction
    function automatic int dead(input int m);  return (m == 0) ? 2 : 0; endfunction
    function automatic bit actlo(input int m); return (m == 0);         endfunction

    function automatic bit [6:0] in_dig(input int m, input int i);
        if (m == 0) return (i < 2) ? sd_a[i[0]] : 7'h00;
        return sd_b[i[1:0]];
    endfunction

    task automatic model_step(input int m);
        bit hs;
        hs = ((m == 0) ? sv_a : sv_b) && !mpend[m];
        mfs[m] = 1'b0;
        if (!mst[m]) begin
            if (mpend[m]) begin
                mst[m] = 1'b1;
                mt[m] = 0;
                for (int i = 0; i < 4; i++) mdisp[m][i] = mpf[m][i];
                mpend[m] = 1'b0;
                mfs[m] = 1'b1;
            end
        end else begin
            mt[m] = mt[m] + 1;
            if (mt[m] == ndig(m) * rdiv(m)) begin
                mt[m] = 0;
                mfs[m] = 1'b1;
                if (mpend[m]) begin
                    for (int i = 0; i < 4; i++) mdisp[m][i] = mpf[m][i];
                    mpend[m] = 1'b0;
                end
            end
        end
        if (hs) begin
            mpend[m] = 1'b1;
            for (int i = 0; i < 4; i++) mpf[m][i] = in_dig(m, i);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mst[m] = 1'b0; mt[m] = 0; mpend[m] = 1'b0; mfs[m] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                mdisp[m][i] = 7'h00;
                mpf[m][i] = 7'h00;
            end
        end
    endtask

    function automatic void expect_out(input int m, output logic [3:0] ean, output logic [6:0] eseg);
        logic [3:0] a;
        logic [6:0] s;
        int slot;
        int pos;
        a = '0;
        s = '0;
        if (mst[m]) begin
            slot = mt[m] / rdiv(m);
            pos  = mt[m] % rdiv(m);
            if (pos >= dead(m)) begin
                a[slot] = 1'b1;
                s = mdisp[m][slot];
            end
        end
        if (actlo(m)) begin
            a = ~a;
            s = ~s;
        end
        ean = a;
        eseg = s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else for (int m = 0; m < 2; m++) model_step(m);
        end
    end

    initial begin
        logic [3:0] ea;
        logic [6:0] es;
        forever begin
            @(negedge clk);
            expect_out(0, ea, es);
            chk("a_an", 32'(an_a), 32'(ea[1:0]));
            chk("a_seg", 32'(seg_a), 32'(es));
            chk("a_fs", 32'(fs_a), 32'(mfs[0]));
            chk("a_rdy", 32'(rdy_a), 32'(!mpend[0]));
            expect_out(1, ea, es);
            chk("b_an", 32'(an_b), 32'(ea));
            chk("b_seg", 32'(seg_b), 32'(es));
            chk("b_fs", 32'(fs_b), 32'(mfs[1]));
            chk("b_rdy", 32'(rdy_b), 32'(!mpend[1]));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic rand_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            sv_a = ($urandom_range(0, 3) == 0);
            sd_a = {7'($urandom), 7'($urandom)};
            sv_b = ($urandom_range(0, 3) == 0);
            sd_b = {7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom)};
        end
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Idle after reset: nothing may move without a frame.
        repeat (50) @(negedge clk);
        chk("rst_an", 32'(an_a), 32'h3);
        chk("rst_seg", 32'(seg_a), 32'h7F);
        chk("rst_rdy", 32'(rdy_a), 32'h1);
        chk("rst_fs", 32'(fs_a), 32'h0);

        // First frame into both instances, then hand-timed checkpoints.
        sv_a = 1'b1;
        sd_a = {7'h06, 7'h3F};
        sv_b = 1'b1;
        sd_b = {7'h4F, 7'h5B, 7'h06, 7'h3F};
        @(posedge clk);
        @(negedge clk);
        sv_a = 1'b0;
        sv_b = 1'b0;
        chk("hs_rdy_low", 32'(rdy_a), 32'h0);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            case (k)
                1: begin
                    chk("k1_fs", 32'(fs_a), 32'h1);
                    chk("k1_an", 32'(an_a), 32'h3);
                    chk("k1_rdy", 32'(rdy_a), 32'h1);
                    chk("k1_b_an", 32'(an_b), 32'h1);
                    chk("k1_b_seg", 32'(seg_b), 32'h3F);
                end
                2: chk("k2_fs", 32'(fs_a), 32'h0);
                3: begin
                    chk("k3_an", 32'(an_a), 32'h2);
                    chk("k3_seg", 32'(seg_a), 32'h40);
                end
                6: begin
                    chk("k6_b_an", 32'(an_b), 32'h2);
                    chk("k6_b_seg", 32'(seg_b), 32'h06);
                end
                8: chk("k8_an", 32'(an_a), 32'h2);
                9: chk("k9_an", 32'(an_a), 32'h3);
                11: begin
                    chk("k11_an", 32'(an_a), 32'h1);
                    chk("k11_seg", 32'(seg_a), 32'h79);
                end
                17: begin
                    chk("k17_fs", 32'(fs_a), 32'h1);
                    chk("k17_an", 32'(an_a), 32'h3);
                end
                21: begin
                    chk("k21_b_fs", 32'(fs_b), 32'h1);
                    chk("k21_b_an", 32'(an_b), 32'h1);
                end
                default: ;
            endcase
        end

        rand_cycles(800);

        // Reset while digit 1 is driven and a frame is pending.
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            sv_a = 1'b1;
            sd_a = {7'($urandom), 7'($urandom)};
            if (mst[0] && (mt[0] / 8 == 1) && (mt[0] % 8 >= 2) && mpend[0]) found = 1'b1;
        end
        chk("rst_wait", 32'(found), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_an", 32'(an_a), 32'h3);
        chk("arst_seg", 32'(seg_a), 32'h7F);
        chk("arst_rdy", 32'(rdy_a), 32'h1);
        chk("arst_fs", 32'(fs_a), 32'h0);
        chk("arst_b_an", 32'(an_b), 32'h0);
        sv_a = 1'b0;
        sv_b = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_rdy", 32'(rdy_a), 32'h1);
        chk("post_rst_an", 32'(an_a), 32'h3);

        rand_cycles(400);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
